// File: rtl/seg7_mux_decoder_if.sv
// Snooped select/segment bus plus decoded readback of the two-digit mux display.
// Purely observational: the decoder never back-pressures the display driver.
interface seg7_mux_decoder_if;
   logic [1:0] select;
   logic [6:0] digital;
   logic [3:0] ones;
   logic [3:0] tens;
   logic       value_valid;
   logic       value_update;
   logic       dir_up;
   logic       dir_valid;
   logic       seg_error;
   logic       select_error;

   modport master (
      output select, digital,
      input  ones, tens, value_valid, value_update, dir_up, dir_valid, seg_error, select_error
   );

   modport slave (
      input  select, digital,
      output ones, tens, value_valid, value_update, dir_up, dir_valid, seg_error, select_error
   );
endinterface

// File: rtl/seg7_mux_decoder.sv
// Decodes a multiplexed 2-digit 7-seg bus back to BCD; publish >= SETTLE_CYCLES+2 cycles
// after the completing slot switch. Passive snooper, no backpressure.
module seg7_mux_decoder #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int STABLE_SCANS   = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input logic               clk,
   input logic               rst,
   seg7_mux_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      S_WAIT,
      S_SETTLE,
      S_HOLD
   } slot_state_e;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 2);
   localparam logic [3:0] STABLE_N    = 4'(STABLE_SCANS);

   slot_state_e state_q, state_d;
   logic [1:0]  sel_q, sel_prev_q;
   logic [6:0]  dig_q;
   logic [7:0]  cnt_q, cnt_d;
   logic        sample;

   logic [3:0]  ones_cap_q, ones_cap_d, tens_cap_q, tens_cap_d;
   logic        ones_vld_q, ones_vld_d, tens_vld_q, tens_vld_d;
   logic [7:0]  cand_q, cand_d;
   logic [3:0]  stable_q, stable_d;

   logic [3:0]  ones_q, ones_d, tens_q, tens_d;
   logic        value_valid_q, value_valid_d;
   logic        value_update_q, value_update_d;
   logic        dir_up_q, dir_up_d, dir_valid_q, dir_valid_d;
   logic        seg_error_q, seg_error_d;
   logic        select_error_q, select_error_d;

   logic        sel_chg, sel_legal;
   logic [6:0]  dig_dec;
   logic [4:0]  dec;
   logic        publish;
   logic [6:0]  old_bin, new_bin, up_bin, dn_bin;

   // Returns {legal, bcd}; legal = 0 for any non-digit pattern.
   function automatic logic [4:0] seg_decode(input logic [6:0] p);
      case (p)
         7'h3F:   return {1'b1, 4'd0};
         7'h06:   return {1'b1, 4'd1};
         7'h5B:   return {1'b1, 4'd2};
         7'h4F:   return {1'b1, 4'd3};
         7'h66:   return {1'b1, 4'd4};
         7'h6D:   return {1'b1, 4'd5};
         7'h7D:   return {1'b1, 4'd6};
         7'h07:   return {1'b1, 4'd7};
         7'h7F:   return {1'b1, 4'd8};
         7'h6F:   return {1'b1, 4'd9};
         default: return 5'b0;
      endcase
   endfunction

   assign sel_chg   = (sel_q != sel_prev_q);
   assign sel_legal = (sel_q == 2'b10) || (sel_q == 2'b01);
   assign dig_dec   = SEG_ACTIVE_LOW ? ~dig_q : dig_q;
   assign dec       = seg_decode(dig_dec);

   // Slot FSM: a select change always restarts settling, which also aborts a pending sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sample  = 1'b0;
      if (sel_chg) begin
         cnt_d   = '0;
         state_d = sel_legal ? S_SETTLE : S_WAIT;
      end else if (state_q == S_SETTLE) begin
         cnt_d = cnt_q + 8'd1;
         if (cnt_q == SETTLE_LAST) begin
            sample  = 1'b1;
            state_d = S_HOLD;
         end
      end
   end

   assign old_bin = ({3'b0, tens_q} * 7'd10) + {3'b0, ones_q};
   assign new_bin = ({3'b0, cand_q[7:4]} * 7'd10) + {3'b0, cand_q[3:0]};
   assign up_bin  = (old_bin == 7'd99) ? 7'd0 : old_bin + 7'd1;
   assign dn_bin  = (old_bin == 7'd0) ? 7'd99 : old_bin - 7'd1;
   assign publish = (stable_q >= STABLE_N) && ((cand_q != {tens_q, ones_q}) || !value_valid_q);

   always_comb begin
      ones_cap_d     = ones_cap_q;
      tens_cap_d     = tens_cap_q;
      ones_vld_d     = ones_vld_q;
      tens_vld_d     = tens_vld_q;
      cand_d         = cand_q;
      stable_d       = stable_q;
      ones_d         = ones_q;
      tens_d         = tens_q;
      value_valid_d  = value_valid_q;
      value_update_d = 1'b0;
      dir_up_d       = dir_up_q;
      dir_valid_d    = dir_valid_q;
      seg_error_d    = 1'b0;
      select_error_d = 1'b0;

      if (ones_vld_q && tens_vld_q) begin
         ones_vld_d = 1'b0;
         tens_vld_d = 1'b0;
         if ({tens_cap_q, ones_cap_q} == cand_q) begin
            stable_d = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
         end else begin
            stable_d = 4'd1;
            cand_d   = {tens_cap_q, ones_cap_q};
         end
      end

      if (sel_chg && !sel_legal) begin
         select_error_d = 1'b1;
         ones_vld_d     = 1'b0;
         tens_vld_d     = 1'b0;
      end

      if (sample) begin
         if (dec[4]) begin
            if (sel_q == 2'b10) begin
               ones_cap_d = dec[3:0];
               ones_vld_d = 1'b1;
            end else begin
               tens_cap_d = dec[3:0];
               tens_vld_d = 1'b1;
            end
         end else begin
            seg_error_d = 1'b1;
            stable_d    = 4'd0;
            if (sel_q == 2'b10) begin
               ones_vld_d = 1'b0;
            end else begin
               tens_vld_d = 1'b0;
            end
         end
      end

      if (publish) begin
         ones_d         = cand_q[3:0];
         tens_d         = cand_q[7:4];
         value_valid_d  = 1'b1;
         value_update_d = 1'b1;
         // Direction is only inferred between two published values.
         if (value_valid_q) begin
            if (new_bin == up_bin) begin
               dir_up_d    = 1'b1;
               dir_valid_d = 1'b1;
            end else if (new_bin == dn_bin) begin
               dir_up_d    = 1'b0;
               dir_valid_d = 1'b1;
            end else begin
               dir_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_WAIT;
         sel_q          <= 2'b00;
         sel_prev_q     <= 2'b00;
         dig_q          <= '0;
         cnt_q          <= '0;
         ones_cap_q     <= '0;
         tens_cap_q     <= '0;
         ones_vld_q     <= 1'b0;
         tens_vld_q     <= 1'b0;
         cand_q         <= '0;
         stable_q       <= '0;
         ones_q         <= '0;
         tens_q         <= '0;
         value_valid_q  <= 1'b0;
         value_update_q <= 1'b0;
         dir_up_q       <= 1'b0;
         dir_valid_q    <= 1'b0;
         seg_error_q    <= 1'b0;
         select_error_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         sel_q          <= bus.select;
         sel_prev_q     <= sel_q;
         dig_q          <= bus.digital;
         cnt_q          <= cnt_d;
         ones_cap_q     <= ones_cap_d;
         tens_cap_q     <= tens_cap_d;
         ones_vld_q     <= ones_vld_d;
         tens_vld_q     <= tens_vld_d;
         cand_q         <= cand_d;
         stable_q       <= stable_d;
         ones_q         <= ones_d;
         tens_q         <= tens_d;
         value_valid_q  <= value_valid_d;
         value_update_q <= value_update_d;
         dir_up_q       <= dir_up_d;
         dir_valid_q    <= dir_valid_d;
         seg_error_q    <= seg_error_d;
         select_error_q <= select_error_d;
      end
   end

   assign bus.ones         = ones_q;
   assign bus.tens         = tens_q;
   assign bus.value_valid  = value_valid_q;
   assign bus.value_update = value_update_q;
   assign bus.dir_up       = dir_up_q;
   assign bus.dir_valid    = dir_valid_q;
   assign bus.seg_error    = seg_error_q;
   assign bus.select_error = select_error_q;

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Scenario bench for seg7_mux_decoder: a display-driver model feeds scans, a decimal model predicts publishes.
module tb_seg7_mux_decoder;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       up;
      logic       dvld;
   } pub_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_mux_decoder_if bus ();
   seg7_mux_decoder_if bus_n ();

   seg7_mux_decoder #(.SETTLE_CYCLES(4), .STABLE_SCANS(2), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   seg7_mux_decoder #(.SETTLE_CYCLES(4), .STABLE_SCANS(2), .SEG_ACTIVE_LOW(1'b1)) dut_n (
      .clk(clk), .rst(rst), .bus(bus_n)
   );

   logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int   n_tests = 0;
   int   n_fail  = 0;
   pub_t mon_q[$];
   int   seg_cnt = 0;
   int   sel_cnt = 0;
   int   upd_n_cnt = 0;

   // Decimal model of the published value and inferred direction.
   int   m_val   = 0;
   bit   m_valid = 1'b0;
   bit   m_up    = 1'b0;
   bit   m_dv    = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.value_update) mon_q.push_back({bus.tens, bus.ones, bus.dir_up, bus.dir_valid});
         if (bus.seg_error) seg_cnt <= seg_cnt + 1;
         if (bus.select_error) sel_cnt <= sel_cnt + 1;
         if (bus_n.value_update) upd_n_cnt <= upd_n_cnt + 1;
      end
   end

   task automatic model_pub(input int v, output pub_t e);
      if (m_valid) begin
         if (v == (m_val + 1) % 100) begin
            m_up = 1'b1; m_dv = 1'b1;
         end else if (v == (m_val + 99) % 100) begin
            m_up = 1'b0; m_dv = 1'b1;
         end else begin
            m_dv = 1'b0;
         end
      end
      m_val   = v;
      m_valid = 1'b1;
      e.tens  = 4'(v / 10);
      e.ones  = 4'(v % 10);
      e.up    = m_up;
      e.dvld  = m_dv;
   endtask

   task automatic drive_slot(input logic [1:0] s, input logic [6:0] d, input int n);
      bus.select  = s;
      bus.digital = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input int v, input int len);
      drive_slot(2'b10, seg_tbl[v % 10], len);
      drive_slot(2'b01, seg_tbl[v / 10], len);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.select    = 2'b10;
      bus.digital   = seg_tbl[7];
      bus_n.select  = 2'b00;
      bus_n.digital = 7'h00;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({bus.ones, bus.tens, bus.value_valid, bus.value_update, bus.dir_up, bus.dir_valid,
           bus.seg_error, bus.select_error} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ones=%0d tens=%0d vv=%b vu=%b du=%b dv=%b se=%b sle=%b, want all 0",
                  bus.ones, bus.tens, bus.value_valid, bus.value_update, bus.dir_up, bus.dir_valid,
                  bus.seg_error, bus.select_error);
      end
      n_tests++;
      if ({bus_n.ones, bus_n.tens, bus_n.value_valid, bus_n.value_update} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_n: got ones=%0d tens=%0d vv=%b vu=%b, want all 0",
                  bus_n.ones, bus_n.tens, bus_n.value_valid, bus_n.value_update);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (bus.value_valid !== 1'b0 || bus.select_error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got vv=%b sle=%b, want 0 0", bus.value_valid, bus.select_error);
      end
   endtask

   task automatic test_static37();
      int   base;
      pub_t e;
      base = mon_q.size();
      model_pub(37, e);
      for (int s = 0; s < 3; s++) scan(37, 200);
      repeat (10) @(negedge clk);
      n_tests++;
      if (mon_q.size() - base != 1) begin
         n_fail++;
         $display("FAIL static37_pulses: got %0d, want 1", mon_q.size() - base);
      end else begin
         n_tests++;
         if (mon_q[base] !== e) begin
            n_fail++;
            $display("FAIL static37_value: got %h, want %h", mon_q[base], e);
         end
      end
      n_tests++;
      if (bus.tens !== 4'd3 || bus.ones !== 4'd7 || bus.value_valid !== 1'b1 || bus.dir_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL static37_outputs: got %0d%0d vv=%b dv=%b, want 37 vv=1 dv=0",
                  bus.tens, bus.ones, bus.value_valid, bus.dir_valid);
      end
   endtask

   task automatic run_sequence(input string name, input int a, input int b, input int c);
      int   base;
      int   vals[3];
      pub_t exp_q[$];
      pub_t e;
      vals[0] = a; vals[1] = b; vals[2] = c;
      base = mon_q.size();
      for (int i = 0; i < 3; i++) begin
         if (!m_valid || vals[i] != m_val) begin
            model_pub(vals[i], e);
            exp_q.push_back(e);
         end
         for (int s = 0; s < 3; s++) scan(vals[i], 12);
      end
      repeat (10) @(negedge clk);
      n_tests++;
      if (mon_q.size() - base != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s_pulses: got %0d, want %0d", name, mon_q.size() - base, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && base + k < mon_q.size(); k++) begin
         n_tests++;
         if (mon_q[base + k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL %s_pub%0d: got %h, want %h", name, k, mon_q[base + k], exp_q[k]);
         end
      end
   endtask

   task automatic test_up_count();
      run_sequence("up", 98, 99, 0);
      n_tests++;
      if (bus.tens !== 4'd0 || bus.ones !== 4'd0 || bus.dir_up !== 1'b1 || bus.dir_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL up_final: got %0d%0d du=%b dv=%b, want 00 du=1 dv=1",
                  bus.tens, bus.ones, bus.dir_up, bus.dir_valid);
      end
   endtask

   task automatic test_down_count();
      run_sequence("down", 1, 0, 99);
      n_tests++;
      if (bus.tens !== 4'd9 || bus.ones !== 4'd9 || bus.dir_up !== 1'b0 || bus.dir_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL down_final: got %0d%0d du=%b dv=%b, want 99 du=0 dv=1",
                  bus.tens, bus.ones, bus.dir_up, bus.dir_valid);
      end
   endtask

   task automatic test_glitch();
      int base, seg0, sel0;
      base = mon_q.size();
      seg0 = seg_cnt;
      sel0 = sel_cnt;
      drive_slot(2'b10, seg_tbl[5], 2);
      drive_slot(2'b01, 7'h00, 10);
      drive_slot(2'b11, seg_tbl[5], 6);
      n_tests++;
      if (seg_cnt - seg0 != 1) begin
         n_fail++;
         $display("FAIL glitch_seg_error: got %0d pulses, want 1", seg_cnt - seg0);
      end
      n_tests++;
      if (sel_cnt - sel0 != 1) begin
         n_fail++;
         $display("FAIL glitch_select_error: got %0d pulses, want 1", sel_cnt - sel0);
      end
      n_tests++;
      if (mon_q.size() != base || bus.tens !== 4'd9 || bus.ones !== 4'd9) begin
         n_fail++;
         $display("FAIL glitch_value: got %0d new pulses value %0d%0d, want 0 pulses value 99",
                  mon_q.size() - base, bus.tens, bus.ones);
      end
   endtask

   task automatic test_back_to_back();
      int   cur, nxt, hold, len, base;
      pub_t exp_q[$];
      pub_t e;
      base = mon_q.size();
      cur  = m_val;
      for (int i = 0; i < 14; i++) begin
         case ($urandom_range(0, 3))
            0:       nxt = (cur + 1) % 100;
            1:       nxt = (cur + 99) % 100;
            2:       nxt = int'($urandom_range(0, 99));
            default: nxt = cur;
         endcase
         hold = int'($urandom_range(2, 3));
         len  = int'($urandom_range(8, 16));
         if (nxt != m_val) begin
            model_pub(nxt, e);
            exp_q.push_back(e);
         end
         for (int s = 0; s < hold; s++) scan(nxt, len);
         cur = nxt;
      end
      repeat (10) @(negedge clk);
      n_tests++;
      if (mon_q.size() - base != exp_q.size()) begin
         n_fail++;
         $display("FAIL random_pulses: got %0d, want %0d", mon_q.size() - base, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && base + k < mon_q.size(); k++) begin
         n_tests++;
         if (mon_q[base + k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL random_pub%0d: got %h, want %h", k, mon_q[base + k], exp_q[k]);
         end
      end
   endtask

   task automatic test_active_low();
      bus_n.digital = 7'h40;
      bus_n.select  = 2'b10;
      repeat (10) @(negedge clk);
      bus_n.select  = 2'b01;
      repeat (10) @(negedge clk);
      n_tests++;
      if (upd_n_cnt != 0 || bus_n.value_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL active_low_early: got %0d pulses vv=%b after one scan, want 0 vv=0",
                  upd_n_cnt, bus_n.value_valid);
      end
      bus_n.select = 2'b10;
      repeat (10) @(negedge clk);
      bus_n.select = 2'b01;
      repeat (10) @(negedge clk);
      n_tests++;
      if (upd_n_cnt != 1 || bus_n.value_valid !== 1'b1 || bus_n.tens !== 4'd0 || bus_n.ones !== 4'd0
          || bus_n.dir_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL active_low_publish: got %0d pulses vv=%b value %0d%0d dv=%b, want 1 vv=1 00 dv=0",
                  upd_n_cnt, bus_n.value_valid, bus_n.tens, bus_n.ones, bus_n.dir_valid);
      end
   endtask

   initial begin
      test_reset();
      test_static37();
      test_up_count();
      test_down_count();
      test_glitch();
      test_back_to_back();
      test_active_low();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_mux_decoder.md
Name: seg7_mux_decoder

Overview:
- Receive-side counterpart of the two-digit multiplexed seven-segment counter display.
- Snoops the time-multiplexed select/digital bus, waits for the segments to settle after each digit switch, and decodes the patterns back to BCD.
- Publishes a stable two-digit value, infers count direction from successive values, and flags illegal bus states.
- Sits beside the display driver as a lab self-check and readback block.

Parameters:
- SETTLE_CYCLES, 4: clk cycles select must hold unchanged before digital is sampled; legal range 2..255.
- STABLE_SCANS, 2: consecutive identical digit pairs required before publishing; legal range 1..15.
- SEG_ACTIVE_LOW, 0: 1 = invert digital before decoding.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- select  input  2  digit enable; 2'b10 = ones digit shown, 2'b01 = tens digit shown; 00 and 11 are illegal
- digital  input  7  segments {g,f,e,d,c,b,a}; bit0 = a; active-high when SEG_ACTIVE_LOW = 0
- ones  output  4  published ones digit, BCD
- tens  output  4  published tens digit, BCD
- value_valid  output  1  high once any value has been published
- value_update  output  1  one-cycle pulse when ones/tens change
- dir_up  output  1  1 = last change was +1 mod 100; 0 = last change was -1 mod 100
- dir_valid  output  1  dir_up is meaningful
- seg_error  output  1  one-cycle pulse: sampled pattern is not a digit 0-9
- select_error  output  1  one-cycle pulse: select became 00 or 11

Behaviour:
- Reset (rst high at a clk edge) clears all outputs to 0, sel_q to 00, settle counter to 0, both slot-captured flags, the candidate pair and the stable count. Reset has priority over every other event, including a sample or publish in the same cycle.
- Input registering: select and digital are registered once (sel_q, dig_q). All decisions use the registered values.
- Slot FSM states:
  - WAIT: no legal select held.
  - SETTLE: counting cycles of unchanged legal select.
  - HOLD: current slot already sampled.
- Slot FSM transitions:
  - Any cycle with sel_q != previous sel_q: settle counter := 0.
    - New value legal: go to SETTLE.
    - New value illegal: pulse select_error, go to WAIT, clear both slot-captured flags.
  - SETTLE: increment the counter each unchanged cycle. The sample is taken on the edge where the counter reaches SETTLE_CYCLES-1, then go to HOLD.
- Decode table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, after optional inversion). Any other pattern:
  - pulse seg_error;
  - discard the sample and clear that slot's captured flag;
  - clear the stable count.
- Pairing:
  - When both slots have been captured, form candidate {tens,ones}, then clear both flags.
  - Candidate equals the previous candidate: stable count increments, saturating at 15.
  - Otherwise: stable count := 1 and the candidate is stored.
- Publish:
  - Condition: stable count reaches STABLE_SCANS and the candidate differs from the published value, or value_valid = 0.
  - On the next edge: ones/tens are loaded, value_valid := 1, and value_update pulses for exactly one cycle.
  - An unchanged stable value never re-pulses.
- Direction, evaluated on each publish after the first (first publish: dir_valid stays 0):
  - new = (old+1) mod 100: dir_up = 1, dir_valid = 1.
  - new = (old-1) mod 100: dir_up = 0, dir_valid = 1.
  - Otherwise: dir_valid = 0, dir_up holds.
  - Wrap: 99->00 is up, 00->99 is down.
- Simultaneous events: a select change on the same cycle the counter would reach SETTLE_CYCLES-1 aborts the sample. Error pulses in consecutive cycles are each reported.
- Latency: publish occurs at least SETTLE_CYCLES+2 cycles after the final completing slot switch.

Test Plan:
- Reset: hold rst 3 cycles with traffic present -> all outputs 0; first legal slot samples only after rst falls.
- Static display of 37 (select alternating, 200 cycles per slot, STABLE_SCANS = 2) -> one value_update, tens = 3, ones = 7, value_valid = 1, dir_valid = 0; no further pulses.
- Up-count 98->99->00 -> two pulses; after each, dir_up = 1 and dir_valid = 1; final tens = 0, ones = 0.
- Down-count 01->00->99 -> dir_up = 0 and dir_valid = 1 after both pulses; final value 99.
- Glitch: select toggled after 2 cycles (SETTLE_CYCLES = 4), then a 7'h00 pattern held, then select = 11 -> no sample from the short slot, one seg_error pulse, one select_error pulse, published value unchanged.
- SEG_ACTIVE_LOW = 1, digital = 7'h40 on both slots -> publishes 00 after two stable scans.
